iob_eth_rx_check: RTL

- Frame checker that sits directly downstream of the Ethernet MII receiver, in the RX_CLK domain.
- Snoops the receiver's buffer-write stream (byte address, byte data, write strobe), the running CRC and the frame-done flag.
- Per frame, it computes byte length, EtherType, CRC pass/fail, runt and giant flags.
- Pushes one status word per completed frame into a small status FIFO, read by the RX_CLK-side DMA/CSR bridge.

---
 rtl/iob_eth_rx_check_pkg.sv | 40 ++++
 rtl/iob_eth_stat_fifo.sv | 62 ++++++
 rtl/iob_eth_rx_check.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/iob_eth_rx_check_pkg.sv
`timescale 1ns/1ps
// iob_eth_rx_check_pkg
// Shared constants for the RX frame checker. It sits alongside
// iob_eth_defs.vh and holds the Ethernet length limits, the CRC residue,
// the bit layout of the status word and the checker FSM encoding.
package iob_eth_rx_check_pkg;

  localparam int          ETH_MIN_LEN     = 64;
  localparam int          ETH_MAX_LEN     = 1518;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hC704DD7B;

  // Status word layout: {giant, runt, crc_ok, type[15:0], len[10:0]}
  localparam int STAT_W     = 30;
  localparam int LEN_LSB    = 0;
  localparam int LEN_W      = 11;
  localparam int TYPE_LSB   = 11;
  localparam int TYPE_W     = 16;
  localparam int CRC_OK_BIT = 27;
  localparam int RUNT_BIT   = 28;
  localparam int GIANT_BIT  = 29;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_CHECK = 3'd2,
    ST_PUSH  = 3'd3,
    ST_WAIT  = 3'd4
  } rx_state_t;

  function automatic logic [STAT_W-1:0] pack_stat(
    input logic [LEN_W-1:0]  len,
    input logic [TYPE_W-1:0] etype,
    input logic              crc_ok,
    input logic              runt,
    input logic              giant
  );
    return {giant, runt, crc_ok, etype, len};
  endfunction

endpackage

// File: rtl/iob_eth_stat_fifo.sv
`timescale 1ns/1ps
// iob_eth_stat_fifo
// Synchronous first-word-fall-through FIFO for frame status words.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   push, din    : write request and data (ignored when full unless a pop
//                  frees a slot in the same cycle)
//   pop          : consume head entry (ignored when empty)
//   dout         : head entry, valid whenever empty is low
//   full, empty  : occupancy flags
//   level        : number of stored entries, 0..2**AW
module iob_eth_stat_fifo #(
  parameter int W  = 30,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/iob_eth_rx_check.sv
`timescale 1ns/1ps
// iob_eth_rx_check
// Snoops the MII receiver's buffer-write stream and produces one status
// word per frame: byte length, EtherType, CRC pass, runt and giant flags.
// Ports:
//   rst, RX_CLK        : asynchronous active-high reset, receive clock
//   rx_wr/addr/data    : receiver byte writes; addr 0 starts (or restarts) a frame
//   crc_value          : receiver running CRC, compared against the residue
//   frame_done         : frame-complete level, held until acknowledged
//   stat_pop           : consume head entry
//   stat_*             : head entry fields, FIFO occupancy, sticky overflow
//   abort_cnt          : saturating count of restarted (filtered) frames
// Handshake: stat_valid/stat_pop -- the head entry is consumed on a rising
// RX_CLK edge where both are high; stat_pop while stat_valid is low is ignored.
module iob_eth_rx_check
  import iob_eth_rx_check_pkg::*;
#(
  parameter int          STAT_AW     = 2,
  parameter int          MIN_LEN     = ETH_MIN_LEN,
  parameter int          MAX_LEN     = ETH_MAX_LEN,
  parameter logic [31:0] CRC_RESIDUE = ETH_CRC_RESIDUE
) (
  input  logic               rst,
  input  logic               RX_CLK,
  input  logic               rx_wr,
  input  logic [10:0]        rx_addr,
  input  logic [7:0]         rx_data,
  input  logic [31:0]        crc_value,
  input  logic               frame_done,
  input  logic               stat_pop,
  output logic               stat_valid,
  output logic [10:0]        stat_len,
  output logic [15:0]        stat_type,
  output logic               stat_crc_ok,
  output logic               stat_runt,
  output logic               stat_giant,
  output logic [STAT_AW:0]   stat_level,
  output logic               stat_ovf,
  output logic [7:0]         abort_cnt
);

  localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
  localparam logic [10:0] CNT_SAT = 11'h7FF;

  rx_state_t          state;
  logic               fd_q;
  logic               fd_rise;
  logic [10:0]        byte_cnt;
  logic [15:0]        etype;
  logic [STAT_W-1:0]  stat_word;
  logic [STAT_W-1:0]  head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               start_byte;

  assign fd_rise    = frame_done & ~fd_q;
  assign start_byte = rx_wr && (rx_addr == 11'd0);

  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      fd_q      <= 1'b0;
      byte_cnt  <= '0;
      etype     <= '0;
      stat_word <= '0;
      stat_ovf  <= 1'b0;
      abort_cnt <= '0;
    end else begin
      fd_q <= frame_done;
      case (state)
        ST_IDLE: begin
          if (start_byte) begin
            byte_cnt <= 11'd1;
            etype    <= '0;
            state    <= ST_COUNT;
          end else if (fd_rise) begin
            // Zero-byte frame: count and type are already cleared.
            state <= ST_CHECK;
          end
        end
        ST_COUNT: begin
          if (start_byte) begin
            // Receiver dropped the frame (DA mismatch) and started over.
            byte_cnt <= 11'd1;
            etype    <= '0;
            if (abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 8'd1;
          end else begin
            if (rx_wr) begin
              // byte_cnt is the index of the byte being written.
              if (byte_cnt == 11'd12) etype[15:8] <= rx_data;
              if (byte_cnt == 11'd13) etype[7:0]  <= rx_data;
              if (byte_cnt != CNT_SAT) byte_cnt <= byte_cnt + 11'd1;
            end
            if (fd_rise) state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          stat_word <= pack_stat(byte_cnt, etype,
                                 crc_value == CRC_RESIDUE,
                                 byte_cnt < MIN_L,
                                 (byte_cnt > MAX_L) || (byte_cnt == CNT_SAT));
          state     <= ST_PUSH;
        end
        ST_PUSH: begin
          if (fifo_full && !stat_pop) stat_ovf <= 1'b1;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // Hold here while frame_done stays high so a frame is pushed once.
          if (!frame_done) begin
            byte_cnt <= '0;
            etype    <= '0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  iob_eth_stat_fifo #(
    .W  (STAT_W),
    .AW (STAT_AW)
  ) u_stat_fifo (
    .clk   (RX_CLK),
    .rst   (rst),
    .push  (state == ST_PUSH),
    .din   (stat_word),
    .pop   (stat_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (stat_level)
  );

  assign stat_valid  = ~fifo_empty;
  assign stat_len    = head[LEN_LSB +: LEN_W];
  assign stat_type   = head[TYPE_LSB +: TYPE_W];
  assign stat_crc_ok = head[CRC_OK_BIT];
  assign stat_runt   = head[RUNT_BIT];
  assign stat_giant  = head[GIANT_BIT];

endmodule
